microprogram_sequencer: RTL
===========================

// Module: microprogram_sequencer
// PURPOSE
//  Next-address generator and pipeline control register for the microcoded control unit.
//  Drives the 6-bit index of the microstore ROM and receives the ROM control word on the same cycle.
//  Selects the next index from: the instruction encoder, an incrementer, the branch field, or a return stack.
//  Latches each control word into cr_out for the datapath.
// PARAMETERS
//  ADDR_W      6   microstore index width
//  CW_W        55  control word width
//  STACK_DEPTH 4   return-stack entries (power of 2)
//  RESET_ADDR  0   index loaded on reset
//  FETCH_ADDR  1   index used when RET pops an empty stack
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       asynchronous, active-high
//  cw_in          in   CW_W    control word from microstore ROM at current rom_index
//  ir_decode_addr in   ADDR_W  microroutine start address from instruction encoder
//  moc            in   1       memory operation complete
//  cond_pass      in   1       condition tester result for current instruction
//  int_req        in   1       pending interrupt request
//  stall          in   1       freeze sequencer, stack and cr_out
//  rom_index      out  ADDR_W  registered microstore address
//  cr_out         out  CW_W    registered control word to the datapath
//  stack_err      out  1       sticky stack overflow/underflow flag
// BEHAVIOUR
//  - Reset (async, dominates stall): rom_index=RESET_ADDR, cr_out=0, sp=0, stack_err=0, stack contents don't-care.
//  - ROM is combinational. Next index is computed from cw_in combinationally and registered on each
//    non-stalled edge. cr_out<=cw_in on the same edge, so cr_out lags rom_index by one cycle.
//  - Field decode from cw_in: NS=[54:52], INV=[51], CS=[50:49], CRA=[48:43].
//  - CS select: 00=moc, 01=cond_pass, 10=constant 1, 11=int_req. The test bit is t = sel ^ INV.
//  - NS modes (inc = rom_index+1, wraps 63->0):
//    000 ENC   next=ir_decode_addr
//    001 INC   next=inc
//    010 JMP   next=CRA
//    011 CBR   next = t ? CRA : inc
//    100 WAIT  next = t ? inc : rom_index (hold). cr_out still reloads with the same word.
//    101 CALL  push inc; next=CRA
//    110 RET   pop; next=top
//    111 CRET  if t, pop and next=top; else next=inc
//  - Stack boundaries:
//    CALL when sp==STACK_DEPTH: push discarded, sp unchanged, next=CRA, stack_err<=1.
//    RET/taken CRET when sp==0: next=FETCH_ADDR, sp unchanged, stack_err<=1.
//  - stall=1: rom_index, cr_out, sp, stack and stack_err all hold. Inputs are ignored.
//  - Reset mid-WAIT or mid-subroutine: the stack is abandoned and execution restarts at RESET_ADDR.
//  - No X-propagation: an unused CS/NS encoding cannot occur, since all 8 NS and 4 CS codes are defined.
// STRUCTURE
//  - Package armsim_uc_pkg: NS_* and CS_* localparam codes, plus field bit positions NS_HI/NS_LO, INV_BIT,
//    CS_HI/CS_LO, CRA_HI/CRA_LO shared with the ROM image and the datapath decoder.
//  - Sub-module uc_return_stack: LIFO with push/pop/top/full/empty. Simultaneous push+pop is never issued.
//  - Top level: condition mux, next-address mux, incrementer, rom_index/cr_out/stack_err registers.
// TESTING
//  1. Reset:
//     - Stimulus: assert reset with clk stopped.
//     - Required: rom_index=0, cr_out=0, stack_err=0 immediately. After release, first edge gives cr_out=ROM[0].
//  2. Encoder dispatch:
//     - Stimulus: cw_in NS=000, ir_decode_addr=6'h0A.
//     - Required: next edge gives rom_index=6'h0A.
//     - Stimulus: NS=001 at index 6'h3F.
//     - Required: rom_index wraps to 6'h00.
//  3. MOC wait:
//     - Stimulus: NS=100, CS=00, INV=0 at index 5, with moc=0 for 3 cycles then 1.
//     - Required: rom_index=5 for 3 edges, then 6. cr_out holds the same word throughout.
//  4. Conditional branch:
//     - Stimulus: NS=011, CS=01, CRA=6'h20 at index 9.
//     - Required: cond_pass=1 gives 6'h20; cond_pass=0 gives 6'h0A. With INV=1, the results swap.
//  5. Call/return:
//     - Stimulus: CALL at index 3 with CRA=6'h28, then RET.
//     - Required: 6'h28 then 6'h04.
//     - Stimulus: 5 nested CALLs (depth 4).
//     - Required: stack_err=1, and the 5th still jumps to CRA.
//     - Stimulus: RET on an empty stack.
//     - Required: rom_index=FETCH_ADDR, stack_err=1.
//  6. Stall:
//     - Stimulus: stall=1 during a CALL.
//     - Required: rom_index, cr_out and sp unchanged.
//     - Stimulus: reset asserted while stall=1.
//     - Required: reset takes effect.

Source files
------------

// File: rtl/armsim_uc_pkg.sv
// armsim_uc_pkg: microword field positions and NS/CS codes shared by ROM image, sequencer and datapath
package armsim_uc_pkg;
    localparam logic [2:0] NS_ENC  = 3'd0;
    localparam logic [2:0] NS_INC  = 3'd1;
    localparam logic [2:0] NS_JMP  = 3'd2;
    localparam logic [2:0] NS_CBR  = 3'd3;
    localparam logic [2:0] NS_WAIT = 3'd4;
    localparam logic [2:0] NS_CALL = 3'd5;
    localparam logic [2:0] NS_RET  = 3'd6;
    localparam logic [2:0] NS_CRET = 3'd7;
    localparam logic [1:0] CS_MOC  = 2'd0;
    localparam logic [1:0] CS_COND = 2'd1;
    localparam logic [1:0] CS_ONE  = 2'd2;
    localparam logic [1:0] CS_INT  = 2'd3;
    localparam int NS_HI   = 54;
    localparam int NS_LO   = 52;
    localparam int INV_BIT = 51;
    localparam int CS_HI   = 50;
    localparam int CS_LO   = 49;
    localparam int CRA_HI  = 48;
    localparam int CRA_LO  = 43;
endpackage

// File: rtl/uc_return_stack.sv
// uc_return_stack: LIFO of return addresses
// Ports: clk, reset (async high), push/pop requests, push_data in, top out, full/empty flags.
// A push while full and a pop while empty are ignored; the caller flags the error.
module uc_return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SP_W = $clog2(DEPTH) + 1;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [SP_W-2:0] wr_ptr, rd_ptr;
    assign full   = sp_q == SP_W'(DEPTH);
    assign empty  = sp_q == '0;
    assign wr_ptr = (SP_W-1)'(sp_q);
    assign rd_ptr = (SP_W-1)'(sp_q - 1'b1);
    assign top    = mem_q[rd_ptr];
    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (push && !full) begin
            mem_d[wr_ptr] = push_data;
            sp_d          = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) sp_q <= '0;
        else       sp_q <= sp_d;
    // Contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk)
        mem_q <= mem_d;
endmodule

// File: rtl/microprogram_sequencer.sv
// microprogram_sequencer: next-address generator and control register for the microcoded control unit
// Ports: clk, reset (async high); cw_in (ROM word at rom_index), ir_decode_addr, moc, cond_pass,
// int_req, stall in; rom_index (registered ROM address), cr_out (registered control word),
// stack_err (sticky stack overflow/underflow) out.
module microprogram_sequencer
    import armsim_uc_pkg::*;
#(
    parameter int                ADDR_W      = 6,
    parameter int                CW_W        = 55,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] FETCH_ADDR  = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW_W-1:0]   cw_in,
    input  logic [ADDR_W-1:0] ir_decode_addr,
    input  logic              moc,
    input  logic              cond_pass,
    input  logic              int_req,
    input  logic              stall,
    output logic [ADDR_W-1:0] rom_index,
    output logic [CW_W-1:0]   cr_out,
    output logic              stack_err
);
    logic [ADDR_W-1:0] rom_index_q, rom_index_d, next_idx, inc, cra, top;
    logic [CW_W-1:0]   cr_out_q, cr_out_d;
    logic              stack_err_q, stack_err_d;
    logic [2:0]        ns;
    logic [1:0]        cs;
    logic              sel, t, push, pop, err, full, empty;
    assign ns  = cw_in[NS_HI:NS_LO];
    assign cs  = cw_in[CS_HI:CS_LO];
    assign cra = cw_in[CRA_HI:CRA_LO];
    assign inc = rom_index_q + 1'b1;
    assign sel = cs == CS_MOC ? moc : cs == CS_COND ? cond_pass : cs == CS_ONE ? 1'b1 : int_req;
    assign t   = sel ^ cw_in[INV_BIT];
    always_comb begin
        next_idx = inc;
        push     = 1'b0;
        pop      = 1'b0;
        err      = 1'b0;
        case (ns)
            NS_ENC:  next_idx = ir_decode_addr;
            NS_INC:  next_idx = inc;
            NS_JMP:  next_idx = cra;
            NS_CBR:  next_idx = t ? cra : inc;
            NS_WAIT: next_idx = t ? inc : rom_index_q;
            NS_CALL: begin
                next_idx = cra;
                push     = 1'b1;
                err      = full;
            end
            NS_RET: begin
                pop      = 1'b1;
                next_idx = empty ? FETCH_ADDR : top;
                err      = empty;
            end
            NS_CRET: begin
                pop      = t;
                next_idx = t ? (empty ? FETCH_ADDR : top) : inc;
                err      = t & empty;
            end
        endcase
        rom_index_d = stall ? rom_index_q : next_idx;
        cr_out_d    = stall ? cr_out_q : cw_in;
        stack_err_d = stack_err_q | (err & ~stall);
    end
    uc_return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push & ~stall),
        .pop       (pop & ~stall),
        .push_data (inc),
        .top       (top),
        .full      (full),
        .empty     (empty)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rom_index_q <= RESET_ADDR;
            cr_out_q    <= '0;
            stack_err_q <= 1'b0;
        end else begin
            rom_index_q <= rom_index_d;
            cr_out_q    <= cr_out_d;
            stack_err_q <= stack_err_d;
        end
    assign rom_index = rom_index_q;
    assign cr_out    = cr_out_q;
    assign stack_err = stack_err_q;
endmodule
